// File: rtl/filter_seq_pkg.sv
// Shared definitions for the edge-detection filter sequencer: stage codes,
// FSM encodings, kernel geometry per stage and default image geometry.
package filter_seq_pkg;

    localparam int unsigned IMG_DIM_DEF    = 20;
    localparam int unsigned ADDR_W_DEF     = 9;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned LANES          = 5;

    // Stage codes, shared with the rest of CHIP
    typedef enum logic [2:0] {
        STG_IDLE    = 3'd0,
        STG_MED_FIL = 3'd1,
        STG_GAU_FIL = 3'd2,
        STG_SOBEL   = 3'd3,
        STG_NON_MAX = 3'd4,
        STG_HYSTER  = 3'd5
    } stage_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET_OP = 3'd1,
        ST_FEED   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    // Kernel side length: 5x5 only for the Gaussian stage
    function automatic logic [2:0] kernel_k(input stage_e s);
        return (s == STG_GAU_FIL) ? 3'd5 : 3'd3;
    endfunction

    // Kernel half-width
    function automatic logic [1:0] kernel_h(input stage_e s);
        return (s == STG_GAU_FIL) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/filter_sequencer_fifo.sv
// seq_addr_fifo: small synchronous FIFO holding write-back addresses of
// results still in flight through the active filter.
module seq_addr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/filter_sequencer.sv
// filter_sequencer: steps the filter stages MED..HYSTER, streams one kernel
// column per beat, queues result write-back addresses and strobes the border
// write-back between stages. Optional FILTER_SEQ_PERF_EN adds busy/stall
// performance counters.
module filter_sequencer
    import filter_seq_pkg::*;
#(
    parameter int unsigned IMG_DIM    = IMG_DIM_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic [2:0]        o_stage,
    output logic              o_col_valid,
    input  logic              i_col_ready,
    output logic [ADDR_W-1:0] o_col_addr0,
    output logic [ADDR_W-1:0] o_col_addr1,
    output logic [ADDR_W-1:0] o_col_addr2,
    output logic [ADDR_W-1:0] o_col_addr3,
    output logic [ADDR_W-1:0] o_col_addr4,
    output logic [4:0]        o_lane_mask,
    output logic              o_row_first,
    input  logic              i_res_valid,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_wb_pulse,
    output logic              o_wb_wide,
    output logic              o_frame_done,
    output logic              o_busy,
`ifdef FILTER_SEQ_PERF_EN
    output logic [15:0]       o_perf_busy,
    output logic [15:0]       o_perf_stall,
`endif
    output logic              o_seq_err
);

    localparam int unsigned CNT_W = $clog2(IMG_DIM);

    state_e            r_state;
    state_e            w_state_nxt;
    stage_e            r_stage;
    stage_e            w_stage_nxt;
    logic [CNT_W-1:0]  r_row;
    logic [CNT_W-1:0]  w_row_nxt;
    logic [CNT_W-1:0]  r_col;
    logic [CNT_W-1:0]  w_col_nxt;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] w_row_base_nxt;
    logic              r_busy;
    logic              r_wb_pulse;
    logic              r_wb_wide;
    logic              r_frame_done;
    logic              r_seq_err;

    logic [2:0]        w_k;
    logic [1:0]        w_h;
    logic              w_last_col;
    logic              w_last_row;
    logic              w_col_valid;
    logic              w_beat;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ADDR_W-1:0] w_head;
    logic [ADDR_W-1:0] w_ctr_off;
    logic [ADDR_W-1:0] w_centre;
    logic [4:0]        w_mask;
    logic [ADDR_W-1:0] w_lane [LANES];

    assign w_k         = kernel_k(r_stage);
    assign w_h         = kernel_h(r_stage);
    assign w_last_col  = (r_col == CNT_W'(IMG_DIM - 1));
    assign w_last_row  = (r_row == CNT_W'(IMG_DIM - 1) - CNT_W'(w_h));
    assign w_col_valid = (r_state == ST_FEED) && !w_fifo_full;
    assign w_beat      = w_col_valid && i_col_ready;
    assign w_push      = w_beat && (r_col >= CNT_W'(w_k) - CNT_W'(1));
    assign w_pop       = i_res_valid && !w_fifo_empty;

    // Centre = r*IMG_DIM + col - h, rebuilt from row_base = (r-h)*IMG_DIM
    assign w_ctr_off = (w_h == 2'd2) ? ADDR_W'(2 * IMG_DIM - 2) : ADDR_W'(IMG_DIM - 1);
    assign w_centre  = r_row_base + ADDR_W'(r_col) + w_ctr_off;

    // Lane enables and kernel-column addresses; everything reads 0 outside FEED
    always_comb begin
        w_mask = 5'b00000;
        if (r_state == ST_FEED) begin
            w_mask = (w_k == 3'd5) ? 5'b11111 : 5'b00111;
        end
        for (int unsigned k = 0; k < LANES; k++) begin
            w_lane[k] = '0;
            if (w_mask[k]) begin
                w_lane[k] = r_row_base + ADDR_W'(r_col) + ADDR_W'(k * IMG_DIM);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, stage and sweep-counter logic
    always_comb begin
        w_state_nxt    = r_state;
        w_stage_nxt    = r_stage;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_row_base_nxt = r_row_base;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_SET_OP;
                    w_stage_nxt = STG_MED_FIL;
                end
            end
            ST_SET_OP: begin
                w_row_nxt      = CNT_W'(w_h);
                w_col_nxt      = '0;
                w_row_base_nxt = '0;
                w_state_nxt    = ST_FEED;
            end
            ST_FEED: begin
                if (w_beat) begin
                    if (w_last_col) begin
                        w_col_nxt      = '0;
                        w_row_nxt      = r_row + CNT_W'(1);
                        w_row_base_nxt = r_row_base + ADDR_W'(IMG_DIM);
                        if (w_last_row) begin
                            w_state_nxt = ST_DRAIN;
                        end
                    end else begin
                        w_col_nxt = r_col + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (w_fifo_empty) begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_WB: begin
                if (r_stage == STG_HYSTER) begin
                    w_state_nxt = ST_IDLE;
                    w_stage_nxt = STG_IDLE;
                end else begin
                    w_state_nxt = ST_SET_OP;
                    w_stage_nxt = stage_e'(r_stage + 3'd1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_stage_nxt = STG_IDLE;
            end
        endcase
    end

    // Sweep counters and registered status outputs (decoded from next state)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage      <= STG_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_row_base   <= '0;
            r_busy       <= 1'b0;
            r_wb_pulse   <= 1'b0;
            r_wb_wide    <= 1'b0;
            r_frame_done <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_stage      <= w_stage_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_row_base   <= w_row_base_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_wb_pulse   <= (w_state_nxt == ST_WB);
            r_wb_wide    <= (w_state_nxt == ST_WB) && (r_stage == STG_GAU_FIL);
            r_frame_done <= (w_state_nxt == ST_WB) && (r_stage == STG_HYSTER);
            r_seq_err    <= r_seq_err | (i_res_valid & w_fifo_empty);
        end
    end

    seq_addr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_centre),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef FILTER_SEQ_PERF_EN
    logic [15:0] r_perf_busy;
    logic [15:0] r_perf_stall;

    // Saturating busy/stall counters, cleared when a frame starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if ((r_state != ST_IDLE) && (r_perf_busy != 16'hFFFF)) begin
                r_perf_busy <= r_perf_busy + 16'd1;
            end
            if ((r_state == ST_FEED) && !w_beat && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign o_perf_busy  = r_perf_busy;
    assign o_perf_stall = r_perf_stall;
`endif

    assign o_stage      = r_stage;
    assign o_col_valid  = w_col_valid;
    assign o_col_addr0  = w_lane[0];
    assign o_col_addr1  = w_lane[1];
    assign o_col_addr2  = w_lane[2];
    assign o_col_addr3  = w_lane[3];
    assign o_col_addr4  = w_lane[4];
    assign o_lane_mask  = w_mask;
    assign o_row_first  = (r_state == ST_FEED) && (r_col == '0);
    assign o_wr_en      = w_pop;
    assign o_wr_addr    = w_head;
    assign o_wb_pulse   = r_wb_pulse;
    assign o_wb_wide    = r_wb_wide;
    assign o_frame_done = r_frame_done;
    assign o_busy       = r_busy;
    assign o_seq_err    = r_seq_err;

endmodule

// File: tb/tb_filter_sequencer.sv
// Directed bench for filter_sequencer: full frame with 2-cycle result latency,
// underflow flag, FIFO backpressure, abort by reset and restart.
module tb_filter_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_start;
    logic       i_col_ready;
    logic       i_res_valid;
    logic [2:0] o_stage;
    logic       o_col_valid;
    logic [8:0] o_col_addr0, o_col_addr1, o_col_addr2, o_col_addr3, o_col_addr4;
    logic [4:0] o_lane_mask;
    logic       o_row_first;
    logic       o_wr_en;
    logic [8:0] o_wr_addr;
    logic       o_wb_pulse;
    logic       o_wb_wide;
    logic       o_frame_done;
    logic       o_busy;
    logic       o_seq_err;

    int checks   = 0;
    int failures = 0;
    int res_mode = 0;   // 0 manual, 1 two-cycle latency, 2 immediate
    bit nogap_en = 0;
    logic [1:0] lat_q = 2'b00;
    int exp_q[$];
    int beat_cnt = 0, push_cnt = 0, wb_cnt = 0, done_cnt = 0;
    int cyc = 0, first_cyc = 0, last_cyc = 0;

    always #5 clk = ~clk;

    filter_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .o_stage      (o_stage),
        .o_col_valid  (o_col_valid),
        .i_col_ready  (i_col_ready),
        .o_col_addr0  (o_col_addr0),
        .o_col_addr1  (o_col_addr1),
        .o_col_addr2  (o_col_addr2),
        .o_col_addr3  (o_col_addr3),
        .o_col_addr4  (o_col_addr4),
        .o_lane_mask  (o_lane_mask),
        .o_row_first  (o_row_first),
        .i_res_valid  (i_res_valid),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wb_pulse   (o_wb_pulse),
        .o_wb_wide    (o_wb_wide),
        .o_frame_done (o_frame_done),
        .o_busy       (o_busy),
        .o_seq_err    (o_seq_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string p);
        chk({p, "_stage"},      32'(o_stage), 0);
        chk({p, "_col_valid"},  32'(o_col_valid), 0);
        chk({p, "_addr0"},      32'(o_col_addr0), 0);
        chk({p, "_addr2"},      32'(o_col_addr2), 0);
        chk({p, "_lane_mask"},  32'(o_lane_mask), 0);
        chk({p, "_row_first"},  32'(o_row_first), 0);
        chk({p, "_wr_en"},      32'(o_wr_en), 0);
        chk({p, "_wr_addr"},    32'(o_wr_addr), 0);
        chk({p, "_wb_pulse"},   32'(o_wb_pulse), 0);
        chk({p, "_wb_wide"},    32'(o_wb_wide), 0);
        chk({p, "_frame_done"}, 32'(o_frame_done), 0);
        chk({p, "_busy"},       32'(o_busy), 0);
        chk({p, "_seq_err"},    32'(o_seq_err), 0);
    endtask

    // One clock: drive result strobe, check the cycle's outputs against the
    // beat-index model, then advance past the next rising edge.
    // Beat b of a stage sits at r = h + b/20, c = b%20, so lane k reads
    // b + 20k and a completed window's centre r*20 + c - h is b + 20h - h.
    task automatic tick();
        int k, h, b, st;
        bit pushed;
        pushed = 0;
        case (res_mode)
            1:       i_res_valid = lat_q[1];
            2:       i_res_valid = (exp_q.size() > 0);
            default: ;
        endcase
        #1;
        if (i_res_valid) begin
            if (exp_q.size() > 0) begin
                chk("wr_en", 32'(o_wr_en), 1);
                chk("wr_addr", 32'(o_wr_addr), exp_q.pop_front());
            end else begin
                chk("underflow_wr_en", 32'(o_wr_en), 0);
            end
        end
        st = int'(o_stage);
        if (o_col_valid && i_col_ready) begin
            k = (st == 2) ? 5 : 3;
            h = k / 2;
            b = beat_cnt;
            if (b == 0) first_cyc = cyc;
            last_cyc = cyc;
            chk("addr0", 32'(o_col_addr0), b);
            chk("addr1", 32'(o_col_addr1), b + 20);
            chk("addr2", 32'(o_col_addr2), b + 40);
            chk("addr3", 32'(o_col_addr3), (k == 5) ? b + 60 : 0);
            chk("addr4", 32'(o_col_addr4), (k == 5) ? b + 80 : 0);
            chk("lane_mask", 32'(o_lane_mask), (k == 5) ? 32'h1f : 32'h07);
            chk("row_first", 32'(o_row_first), ((b % 20) == 0) ? 1 : 0);
            if ((b % 20) >= k - 1) begin
                exp_q.push_back(b + 20 * h - h);
                push_cnt++;
                pushed = 1;
            end
            beat_cnt++;
        end
        if (o_wb_pulse) begin
            chk("wb_stage", 32'(o_stage), wb_cnt + 1);
            chk("wb_wide", 32'(o_wb_wide), (st == 2) ? 1 : 0);
            chk("stage_beats", beat_cnt, (st == 2) ? 320 : 360);
            chk("stage_pushes", push_cnt, (st == 2) ? 256 : 324);
            chk("wb_fifo_drained", exp_q.size(), 0);
            if (nogap_en) chk("beats_back_to_back", last_cyc - first_cyc, beat_cnt - 1);
            wb_cnt++;
            beat_cnt = 0;
            push_cnt = 0;
        end
        if (o_frame_done) begin
            done_cnt++;
            chk("done_stage", 32'(o_stage), 5);
        end
        lat_q = {lat_q[0], pushed};
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset = 1'b1; i_start = 1'b0; i_col_ready = 1'b0; i_res_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Result strobe with nothing queued: flag, no write
        i_res_valid = 1'b1;
        tick();
        i_res_valid = 1'b0;
        chk("seq_err_set", 32'(o_seq_err), 1);

        // Full frame, 2-cycle result latency, ready always high
        i_col_ready = 1'b1; res_mode = 1; nogap_en = 1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_busy", 32'(o_busy), 1);
        chk("start_stage", 32'(o_stage), 1);
        chk("set_op_no_beat", 32'(o_col_valid), 0);
        for (int n = 0; n < 3000 && done_cnt == 0; n++) tick();
        tick();
        tick();
        chk("frame_done_count", done_cnt, 1);
        chk("wb_count", wb_cnt, 5);
        chk("post_frame_busy", 32'(o_busy), 0);
        chk("post_frame_stage", 32'(o_stage), 0);
        chk("seq_err_sticky", 32'(o_seq_err), 1);

        // Backpressure: no results, FIFO fills after 4 pushes
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_clears_seq_err", 32'(o_seq_err), 0);
        reset = 1'b0;
        res_mode = 0; i_res_valid = 1'b0; nogap_en = 0; lat_q = 2'b00;
        exp_q.delete(); beat_cnt = 0; push_cnt = 0; wb_cnt = 0; done_cnt = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int n = 0; n < 12; n++) tick();
        chk("bp_beats", beat_cnt, 6);
        chk("bp_queued", exp_q.size(), 4);
        chk("bp_col_valid", 32'(o_col_valid), 0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_ignored_stage", 32'(o_stage), 1);
        chk("start_ignored_beats", beat_cnt, 6);
        i_res_valid = 1'b1;
        tick();
        i_res_valid = 1'b0;
        chk("bp_resume_valid", 32'(o_col_valid), 1);
        chk("bp_resume_addr0", 32'(o_col_addr0), 6);

        // Run on into SOBEL, then abort with reset
        res_mode = 2;
        for (int n = 0; n < 2000 && !(o_stage == 3'd3 && beat_cnt >= 50); n++) tick();
        chk("sobel_reached", 32'(o_stage), 3);
        chk("sobel_wb_count", wb_cnt, 2);
        res_mode = 0; i_res_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk("abort_async_busy", 32'(o_busy), 0);
        @(posedge clk);
        #1;
        chk_idle_outputs("abort");
        tick();
        tick();
        chk("abort_no_wb", wb_cnt, 2);
        chk("abort_no_done", done_cnt, 0);
        reset = 1'b0;

        // Restart from stage 1
        exp_q.delete(); beat_cnt = 0; push_cnt = 0; wb_cnt = 0; lat_q = 2'b00;
        res_mode = 1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("restart_stage", 32'(o_stage), 1);
        chk("restart_busy", 32'(o_busy), 1);
        chk("restart_set_op", 32'(o_col_valid), 0);
        tick();
        chk("restart_valid", 32'(o_col_valid), 1);
        chk("restart_addr0", 32'(o_col_addr0), 0);
        chk("restart_addr1", 32'(o_col_addr1), 20);
        chk("restart_addr2", 32'(o_col_addr2), 40);
        chk("restart_mask", 32'(o_lane_mask), 32'h07);
        chk("restart_row_first", 32'(o_row_first), 1);
        for (int n = 0; n < 30; n++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
